mainfsm: RTL and testbench
==========================

# mainfsm

- Moore finite-state machine at the core of the multicycle processor controller.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Generates the unconditional datapath strobes (`irwrite`, `nextpc`, `regw`, `memw`, `branch`) and the datapath mux selects.
- Its `nextpc`, `regw`, `memw` and `branch` outputs drive the `nextpc`, `regw`, `memw` and `pcs` inputs of the conditional-execution logic, which gates them with the condition result.

## Interface
Parameters: none.

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high; forces state to FETCH immediately
- `op`  in  2  instruction bits [27:26] from the instruction register
- `funct`  in  6  instruction bits [25:20]; `funct[5]` = I (immediate), `funct[0]` = S/L (load)
- `irwrite`  out  1  instruction register write enable
- `adrsrc`  out  1  memory address select (0 = PC, 1 = ALU result)
- `alusrca`  out  1  ALU A select (0 = register, 1 = PC)
- `alusrcb`  out  2  ALU B select (00 = register, 01 = extended immediate, 10 = constant 4)
- `resultsrc`  out  2  result select (00 = ALUOut, 01 = Data, 10 = ALUResult)
- `nextpc`  out  1  unconditional PC write
- `regw`  out  1  register write request (pre-condition)
- `memw`  out  1  memory write request (pre-condition)
- `branch`  out  1  branch request; wired to `pcs` of the conditional logic
- `aluop`  out  1  1 = ALU decoder uses `funct`; 0 = force ADD
- `state`  out  4  current state code, for debug and verification

## Operation
- State register: 4 bits; `state` output is the register directly.
- Outputs are a pure combinational decode of `state`; there are no input-to-output paths.
- Any output not listed for a state is 0.

State codes, outputs and transitions:
- FETCH (0): `irwrite`=1, `nextpc`=1, `adrsrc`=0, `alusrca`=1, `alusrcb`=10, `resultsrc`=10, `aluop`=0. Next state: DECODE.
- DECODE (1): `alusrca`=1, `alusrcb`=10, `resultsrc`=10, `aluop`=0. Next state from `op`:
  - `op`=01 → MEMADR
  - `op`=00 and `funct[5]`=0 → EXECUTER
  - `op`=00 and `funct[5]`=1 → EXECUTEI
  - `op`=10 → BRANCH
  - `op`=11 → UNKNOWN
- MEMADR (2): `alusrca`=0, `alusrcb`=01, `aluop`=0. Next state: MEMREAD if `funct[0]`=1, else MEMWRITE.
- MEMREAD (3): `adrsrc`=1, `resultsrc`=00. Next state: MEMWB.
- MEMWB (4): `resultsrc`=01, `regw`=1. Next state: FETCH.
- MEMWRITE (5): `adrsrc`=1, `resultsrc`=00, `memw`=1. Next state: FETCH.
- EXECUTER (6): `alusrca`=0, `alusrcb`=00, `aluop`=1. Next state: ALUWB.
- EXECUTEI (7): `alusrca`=0, `alusrcb`=01, `aluop`=1. Next state: ALUWB.
- ALUWB (8): `resultsrc`=00, `regw`=1. Next state: FETCH.
- BRANCH (9): `alusrca`=0, `alusrcb`=01, `resultsrc`=10, `aluop`=0, `branch`=1. Next state: FETCH.
- UNKNOWN (10): all outputs 0. Next state: FETCH.
- Codes 11–15 are illegal: all outputs 0, next state FETCH (self-recovery).

Input sampling:
- `op` and `funct` are sampled only in DECODE and MEMADR.
- They are stable there because `irwrite` is asserted only in FETCH.
- Inputs are ignored in every other state.

## Timing
- Reset:
  - Asserting `reset` forces `state`=0 asynchronously, without waiting for a clock edge.
  - While reset is held, outputs show the FETCH decode: `irwrite`=1, `nextpc`=1, `alusrca`=1, `alusrcb`=10, `resultsrc`=10, all others 0.
  - The first FETCH completes on the first rising edge after `reset` deasserts.
- Reset mid-instruction:
  - The instruction is abandoned with no further `regw`/`memw` pulses.
  - Outputs change to the FETCH decode in the same cycle that reset asserts.
- Cycles per instruction, counted from FETCH:
  - LDR: 5 (F, D, MA, MR, MWB)
  - STR: 4 (F, D, MA, MW)
  - Data-processing, register or immediate: 4 (F, D, EX, AWB)
  - B: 3 (F, D, BR)
  - Undefined `op`=11: 3 (F, D, UNKNOWN)
- Pulse widths: `regw`, `memw`, `branch`, `irwrite` and `nextpc` are each exactly one cycle per instruction. They are never asserted together, except `irwrite` with `nextpc` in FETCH.
- Back-to-back instructions: the writeback or terminal state is always followed by FETCH on the next edge, with no idle cycles.

## Test plan
- Reset: hold `reset` for 3 cycles, then release.
  - During reset: `state`=0, `irwrite`=1, `nextpc`=1, `regw`=0, `memw`=0.
  - After release, states are 0 → 1.
- LDR (`op`=01, `funct`=011001):
  - `state` sequence 0,1,2,3,4,0.
  - `regw`=1 only in state 4, with `resultsrc`=01.
  - `adrsrc`=1 in state 3.
- STR (`op`=01, `funct`=011000):
  - `state` sequence 0,1,2,5,0.
  - `memw`=1 only in state 5; `regw` never asserted.
- Data-processing:
  - ADD register (`op`=00, `funct`=001000): sequence 0,1,6,8,0; `aluop`=1 and `alusrcb`=00 in state 6.
  - ORR immediate (`funct`=111000): sequence 0,1,7,8,0; `alusrcb`=01 in state 7.
- Branch and illegal op:
  - `op`=10: sequence 0,1,9,0; `branch`=1 only in state 9.
  - `op`=11: sequence 0,1,10,0; all outputs 0 in state 10.
- Robustness:
  - Assert `reset` asynchronously between edges while in state 3: `state`=0 before the next edge; no `regw` pulse follows.
  - Force the state register to 13: next edge `state`=0; outputs all 0 while in 13.

Source files
------------

// File: rtl/mainfsm.sv
// Multicycle processor main controller: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Outputs decode the state register only; reset asynchronously returns to FETCH.
module mainfsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       irwrite,
  output logic       adrsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       nextpc,
  output logic       regw,
  output logic       memw,
  output logic       branch,
  output logic       aluop,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  logic [3:0] state_q, state_d;
  logic       unused_funct;

  assign unused_funct = ^funct[4:1];
  assign state        = state_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      // Terminal states and illegal codes 11-15 all fall back to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    irwrite   = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    case (state_q)
      S_FETCH: begin
        irwrite   = 1'b1;
        nextpc    = 1'b1;
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_MEMADR:   alusrcb = 2'b01;
      S_MEMREAD:  adrsrc  = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: aluop = 1'b1;
      S_EXECUTEI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      S_ALUWB:    regw = 1'b1;
      S_BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Bench for mainfsm: directed instruction classes, async reset, illegal-state recovery, then random instructions.
module tb_mainfsm;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       irwrite, adrsrc, alusrca, nextpc, regw, memw, branch, aluop;
  logic [1:0] alusrcb, resultsrc;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .irwrite(irwrite), .adrsrc(adrsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .resultsrc(resultsrc), .nextpc(nextpc), .regw(regw), .memw(memw),
    .branch(branch), .aluop(aluop), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] pk(input logic ir, input logic ad, input logic aa,
                                     input logic [1:0] ab, input logic [1:0] rs,
                                     input logic np, input logic rw, input logic mw,
                                     input logic br, input logic ao);
    return {ir, ad, aa, ab, rs, np, rw, mw, br, ao};
  endfunction

  // Output table written straight from the state descriptions; unlisted outputs are 0.
  function automatic logic [12:0] exp_out(input int s);
    case (s)
      0:       return pk(1, 0, 1, 2'b10, 2'b10, 1, 0, 0, 0, 0);
      1:       return pk(0, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, 0);
      2:       return pk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
      3:       return pk(0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
      4:       return pk(0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 0);
      5:       return pk(0, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0);
      6:       return pk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1);
      7:       return pk(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1);
      8:       return pk(0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 0);
      9:       return pk(0, 0, 0, 2'b01, 2'b10, 0, 0, 0, 1, 0);
      default: return 13'd0;
    endcase
  endfunction

  function automatic logic [12:0] obs_out();
    return {irwrite, adrsrc, alusrca, alusrcb, resultsrc, nextpc, regw, memw, branch, aluop};
  endfunction

  // Instruction class -> visited state list.
  function automatic void exp_seq(input logic [1:0] o, input logic [5:0] f, output int q[$]);
    q = {};
    if (o == 2'b01 && f[0])       q = {0, 1, 2, 3, 4};
    else if (o == 2'b01)          q = {0, 1, 2, 5};
    else if (o == 2'b00 && !f[5]) q = {0, 1, 6, 8};
    else if (o == 2'b00)          q = {0, 1, 7, 8};
    else if (o == 2'b10)          q = {0, 1, 9};
    else                          q = {0, 1, 10};
  endfunction

  // Called mid-cycle while in FETCH; returns #1 after the edge that starts the next FETCH.
  task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] f);
    int q[$];
    int n_rw, n_mw, n_br, n_ir, n_np;
    bit is_ld, is_st, is_dp;
    n_rw = 0; n_mw = 0; n_br = 0; n_ir = 0; n_np = 0;
    op = o; funct = f;
    exp_seq(o, f, q);
    for (int i = 0; i < q.size(); i++) begin
      check({name, ".state"}, 32'(state), 32'(q[i]));
      check({name, ".outs"}, 32'(obs_out()), 32'(exp_out(q[i])));
      n_rw += int'(regw); n_mw += int'(memw); n_br += int'(branch);
      n_ir += int'(irwrite); n_np += int'(nextpc);
      if (q[i] >= 3) begin
        op = 2'($urandom); funct = 6'($urandom);
      end
      @(posedge clk); #1;
    end
    check({name, ".wrap"}, 32'(state), 32'd0);
    is_ld = (o == 2'b01) && f[0];
    is_st = (o == 2'b01) && !f[0];
    is_dp = (o == 2'b00);
    check({name, ".regw_cnt"}, 32'(n_rw), 32'((is_ld || is_dp) ? 1 : 0));
    check({name, ".memw_cnt"}, 32'(n_mw), 32'(is_st ? 1 : 0));
    check({name, ".branch_cnt"}, 32'(n_br), 32'((o == 2'b10) ? 1 : 0));
    check({name, ".irwrite_cnt"}, 32'(n_ir), 32'd1);
    check({name, ".nextpc_cnt"}, 32'(n_np), 32'd1);
  endtask

  initial begin
    logic [1:0] ro;
    logic [5:0] rf;
    reset = 1'b1; op = 2'b00; funct = 6'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst.state", 32'(state), 32'd0);
      check("rst.outs", 32'(obs_out()), 32'(exp_out(0)));
      @(posedge clk); #1;
    end
    @(negedge clk); reset = 1'b0; #1;
    check("rst.release", 32'(state), 32'd0);

    run_instr("ldr", 2'b01, 6'b011001);
    run_instr("str", 2'b01, 6'b011000);
    run_instr("add_r", 2'b00, 6'b001000);
    run_instr("orr_i", 2'b00, 6'b111000);
    run_instr("b", 2'b10, 6'b000000);
    run_instr("undef", 2'b11, 6'b000000);

    // Async reset while in MEMREAD of a load
    op = 2'b01; funct = 6'b011001;
    repeat (3) begin @(posedge clk); #1; end
    check("arst.pre", 32'(state), 32'd3);
    #2; reset = 1'b1; #1;
    check("arst.state", 32'(state), 32'd0);
    check("arst.outs", 32'(obs_out()), 32'(exp_out(0)));
    @(posedge clk); #1;
    check("arst.hold_regw", 32'(regw), 32'd0);
    @(negedge clk); reset = 1'b0; #1;
    check("arst.rel_regw", 32'(regw), 32'd0);
    run_instr("post_arst", 2'b10, 6'b000000);

    // Illegal code recovery
    force dut.state_q = 4'd13;
    #1;
    check("ill.state", 32'(state), 32'd13);
    check("ill.outs", 32'(obs_out()), 32'd0);
    release dut.state_q;
    #1;
    check("ill.held", 32'(state), 32'd13);
    @(posedge clk); #1;
    check("ill.recover", 32'(state), 32'd0);
    run_instr("post_ill", 2'b01, 6'b000001);

    for (int n = 0; n < 200; n++) begin
      ro = 2'($urandom);
      rf = 6'($urandom);
      run_instr("rand", ro, rf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
